mini_backtrack_unit: RTL and testbench
======================================

MINI_BACKTRACK_UNIT -- requirements
Module: mini_backtrack_unit

Interface
REQ-001 SHALL have parameter DEPTH, default MAX_VARS (256), meaning trail and decision-stack capacity in entries.
REQ-002 SHALL have parameter VAR_W, default 32, meaning variable-id width; it matches decision_entry_t.var_id.
REQ-003 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port clear, input, 1, a synchronous flush of both stacks (solver restart).
REQ-006 SHALL have ports push_valid (input, 1), push_var (input, VAR_W), push_val (input, assign_val_t), push_is_decision (input, 1) and push_flipped (input, 1), which record one assignment.
REQ-007 SHALL have port bt_req, input, 1, a single-cycle conflict pulse that requests a backtrack.
REQ-008 SHALL have port bt_busy, output, 1, high while unwinding.
REQ-009 SHALL have ports unassign_valid (output, 1), unassign_var (output, VAR_W) and unassign_ready (input, 1), forming a valid/ready stream of variables to clear.
REQ-010 SHALL have ports flip_valid (output, 1), flip_var (output, VAR_W) and flip_val (output, assign_val_t), a 1-cycle flipped-decision command.
REQ-011 SHALL have port unsat, output, 1, a 1-cycle pulse meaning no untried decision remains.
REQ-012 SHALL have port level, output, LEVEL_W, equal to the current decision-stack depth.
REQ-013 SHALL have port trail_count, output, $clog2(DEPTH)+1, equal to the number of trail entries.
REQ-014 SHALL have port overflow, output, 1, a sticky flag set by a push while full.

Function
REQ-015 SHALL keep a trail LIFO of {var, is_decision} and a decision LIFO of decision_entry_t.
REQ-016 SHALL, in IDLE, accept push_valid: it appends to the trail; if push_is_decision, it also pushes a decision entry with tried_pos=(push_val==VAL_TRUE), tried_neg=(push_val==VAL_FALSE), and both set if push_flipped.
REQ-017 SHALL, on a push while trail_count==DEPTH, drop the entry and set overflow; overflow is cleared only by rst or clear.
REQ-018 SHALL ignore push_valid while bt_busy and SHALL set overflow in that case, because it is a protocol error.
REQ-019 SHALL implement the FSM states IDLE, UNWIND, FLIP, UNSAT (bt_state_t).
REQ-020 SHALL, on bt_req in IDLE at cycle N, enter UNWIND with bt_busy=1 at N+1; bt_req outside IDLE is ignored.
REQ-021 SHALL, in UNWIND with the decision LIFO empty, go to UNSAT; level-0 trail entries are retained.
REQ-022 SHALL, in UNWIND with the decision LIFO non-empty, drive unassign_valid=1 and unassign_var=trail top; on handshake (valid&&ready) it pops the trail.
REQ-023 SHALL, when the popped trail entry has is_decision=1, inspect the decision-LIFO top.
REQ-024 SHALL, if both polarities are tried, pop that decision entry, decrement level and remain in UNWIND.
REQ-025 SHALL, if one polarity is untried, pop that decision entry, decrement level, latch the var and the untried polarity, and go to FLIP.
REQ-026 SHALL sustain one pop per cycle while unassign_ready=1; unassign_valid/var SHALL hold stable while ready=0.
REQ-027 SHALL, in FLIP, assert flip_valid for exactly 1 cycle (no backpressure), then return to IDLE with bt_busy=0; the solver re-pushes the flipped decision with push_flipped=1.
REQ-028 SHALL, in UNSAT, pulse unsat for 1 cycle, then return to IDLE.
REQ-029 SHALL give clear priority over every other input: both LIFOs empty, level=0, FSM to IDLE, outputs deasserted, overflow cleared.
REQ-030 SHALL never make a trail pop and a push in the same cycle, because pushes occur only in IDLE.

Reset
REQ-031 SHALL, on rst, set state=IDLE, both LIFO pointers=0, level=0, trail_count=0, and bt_busy, unassign_valid, flip_valid, unsat and overflow all 0; unassign_var/flip_var=0 and flip_val=VAL_UNDEF.
REQ-032 SHALL honour rst mid-UNWIND within one cycle and SHALL NOT let any partial pop or flip complete.

Structure
REQ-033 SHALL place bt_state_t and trail_entry_t {var_id, is_decision} in mini_pkg, reusing assign_val_t, decision_entry_t and LEVEL_W.
REQ-034 SHALL use one parameterised sub-module, mini_lifo (push/pop/top/count/full/empty, sync reset and clear), instantiated twice.
REQ-035 SHALL target 120-400 RTL lines in total.

Verification
REQ-036 SHALL cover: push decision v1=TRUE, implied v2, v3; bt_req; ready=1 -> unassign v3, v2, v1 on consecutive cycles, then flip_var=1, flip_val=VAL_FALSE for 1 cycle; level 1->0.
REQ-037 SHALL cover: push v1=FALSE with push_flipped=1, implied v4; bt_req -> unassign v4, v1; unsat pulses; level=0; trail_count=0.
REQ-038 SHALL cover: implied v7 at level 0 with an empty decision LIFO; bt_req -> no unassign, unsat at N+2, trail_count stays 1.
REQ-039 SHALL cover: two levels (v1 flipped, v2 TRUE, v5 implied); ready toggling 1/0 -> unassign v5, v2 with var stable during stalls; flip v2=FALSE; level=1.
REQ-040 SHALL cover: 256 pushes, then a 257th push -> trail_count=256 and overflow=1; clear -> overflow=0 and trail_count=0.
REQ-041 SHALL cover: rst asserted mid-UNWIND -> next cycle bt_busy=0, unassign_valid=0, level=0, and no flip or unsat pulse.

Source files
------------

// File: rtl/mini_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mini_pkg                                                             |
// | Shared types for the backtrack unit: values, stack entries, states.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mini_pkg;

    localparam int MAX_VARS = 256;
    localparam int LEVEL_W  = $clog2(MAX_VARS) + 1;
    localparam int c_var_w  = 32;

    typedef enum logic [1:0] {
        VAL_UNDEF = 2'd0,
        VAL_FALSE = 2'd1,
        VAL_TRUE  = 2'd2
    } assign_val_t;

    typedef struct packed {
        logic [c_var_w-1:0] var_id;
        logic               tried_pos;
        logic               tried_neg;
    } decision_entry_t;

    typedef struct packed {
        logic [c_var_w-1:0] var_id;
        logic               is_decision;
    } trail_entry_t;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_unwind = 2'd1;
    localparam logic [1:0] c_st_flip   = 2'd2;
    localparam logic [1:0] c_st_unsat  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = c_st_idle,
        UNWIND = c_st_unwind,
        FLIP   = c_st_flip,
        UNSAT  = c_st_unsat
    } bt_state_t;

    // A decision with a single tried polarity flips to the other one.
    function automatic assign_val_t untried_val(input decision_entry_t d);
        return d.tried_pos ? VAL_FALSE : VAL_TRUE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mini_lifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mini_lifo                                                            |
// | Parameterised LIFO with combinational top, sync reset and clear.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mini_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [CNT_W-1:0]    r_count;
    logic [c_addr_w-1:0] w_wr_addr;
    logic [c_addr_w-1:0] w_top_addr;

    assign w_wr_addr  = c_addr_w'(r_count);
    assign w_top_addr = c_addr_w'(r_count - CNT_W'(1));
    assign full       = (r_count == CNT_W'(DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign top        = r_mem[w_top_addr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (push && !full) begin
            r_count <= r_count + CNT_W'(1);
        end else if (pop && !empty) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage is left unreset; only the pointer defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && !clear && push && !full) begin
            r_mem[w_wr_addr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mini_backtrack_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mini_backtrack_unit                                                  |
// | Trail/decision stacks with conflict-driven unwind, flip and UNSAT.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mini_backtrack_unit
    import mini_pkg::*;
#(
    parameter int DEPTH = MAX_VARS,
    parameter int VAR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push_valid,
    input  logic [VAR_W-1:0]           push_var,
    input  assign_val_t                push_val,
    input  logic                       push_is_decision,
    input  logic                       push_flipped,
    input  logic                       bt_req,
    output logic                       bt_busy,
    output logic                       unassign_valid,
    output logic [VAR_W-1:0]           unassign_var,
    input  logic                       unassign_ready,
    output logic                       flip_valid,
    output logic [VAR_W-1:0]           flip_var,
    output assign_val_t                flip_val,
    output logic                       unsat,
    output logic [LEVEL_W-1:0]         level,
    output logic [$clog2(DEPTH):0]     trail_count,
    output logic                       overflow
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    bt_state_t       r_state;
    bt_state_t       w_state_next;
    trail_entry_t    w_trail_din;
    trail_entry_t    w_trail_top;
    decision_entry_t w_dec_din;
    decision_entry_t w_dec_top;
    logic [c_cnt_w-1:0] w_dec_count;
    logic            w_trail_push;
    logic            w_trail_pop;
    logic            w_trail_full;
    logic            w_trail_empty;
    logic            w_dec_push;
    logic            w_dec_pop;
    logic            w_dec_full;
    logic            w_dec_empty;
    logic            w_push_ok;
    logic            w_flip_load;
    logic [VAR_W-1:0] r_flip_var;
    assign_val_t     r_flip_val;
    logic            r_overflow;

    assign w_push_ok    = push_valid && (r_state == IDLE) && !clear && !w_trail_full;
    assign w_trail_push = w_push_ok;
    assign w_dec_push   = w_push_ok && push_is_decision && !w_dec_full;

    assign w_trail_din.var_id      = c_var_w'(push_var);
    assign w_trail_din.is_decision = push_is_decision;
    assign w_dec_din.var_id        = c_var_w'(push_var);
    assign w_dec_din.tried_pos     = push_flipped || (push_val == VAL_TRUE);
    assign w_dec_din.tried_neg     = push_flipped || (push_val == VAL_FALSE);

    mini_lifo #(
        .WIDTH ($bits(trail_entry_t)),
        .DEPTH (DEPTH)
    ) u_trail (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (w_trail_push),
        .push_data (w_trail_din),
        .pop       (w_trail_pop),
        .top       (w_trail_top),
        .count     (trail_count),
        .full      (w_trail_full),
        .empty     (w_trail_empty)
    );

    mini_lifo #(
        .WIDTH ($bits(decision_entry_t)),
        .DEPTH (DEPTH)
    ) u_dec (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (w_dec_push),
        .push_data (w_dec_din),
        .pop       (w_dec_pop),
        .top       (w_dec_top),
        .count     (w_dec_count),
        .full      (w_dec_full),
        .empty     (w_dec_empty)
    );

    assign level    = LEVEL_W'(w_dec_count);
    assign flip_var = r_flip_var;
    assign flip_val = r_flip_val;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_trail_pop    = 1'b0;
        w_dec_pop      = 1'b0;
        w_flip_load    = 1'b0;
        unassign_valid = 1'b0;
        unassign_var   = '0;
        flip_valid     = 1'b0;
        unsat          = 1'b0;
        bt_busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (bt_req) begin
                    w_state_next = UNWIND;
                end
            end
            UNWIND: begin
                // Level-0 entries stay on the trail once no decision is left.
                if (w_dec_empty || w_trail_empty) begin
                    w_state_next = UNSAT;
                end else begin
                    unassign_valid = 1'b1;
                    unassign_var   = VAR_W'(w_trail_top.var_id);
                    if (unassign_ready) begin
                        w_trail_pop = 1'b1;
                        if (w_trail_top.is_decision) begin
                            w_dec_pop = 1'b1;
                            if (!(w_dec_top.tried_pos && w_dec_top.tried_neg)) begin
                                w_flip_load  = 1'b1;
                                w_state_next = FLIP;
                            end
                        end
                    end
                end
            end
            FLIP: begin
                flip_valid   = 1'b1;
                w_state_next = IDLE;
            end
            UNSAT: begin
                unsat        = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (clear) begin
            w_state_next   = IDLE;
            w_trail_pop    = 1'b0;
            w_dec_pop      = 1'b0;
            w_flip_load    = 1'b0;
            unassign_valid = 1'b0;
            unassign_var   = '0;
            flip_valid     = 1'b0;
            unsat          = 1'b0;
            bt_busy        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_flip_var <= '0;
            r_flip_val <= VAL_UNDEF;
        end else if (w_flip_load) begin
            r_flip_var <= VAR_W'(w_dec_top.var_id);
            r_flip_val <= untried_val(w_dec_top);
        end
    end

    // A push while busy is a protocol error and is flagged like a full-stack drop.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_overflow <= 1'b0;
        end else if (push_valid && ((r_state != IDLE) || w_trail_full)) begin
            r_overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mini_backtrack_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mini_backtrack_unit                                               |
// | Directed and random backtrack scenarios against a queue-based model. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mini_backtrack_unit;
    import mini_pkg::*;

    localparam int DEPTH = 256;
    localparam int VAR_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             push_valid;
    logic [VAR_W-1:0] push_var;
    assign_val_t      push_val;
    logic             push_is_decision;
    logic             push_flipped;
    logic             bt_req;
    logic             bt_busy;
    logic             unassign_valid;
    logic [VAR_W-1:0] unassign_var;
    logic             unassign_ready;
    logic             flip_valid;
    logic [VAR_W-1:0] flip_var;
    assign_val_t      flip_val;
    logic             unsat;
    logic [LEVEL_W-1:0] level;
    logic [$clog2(DEPTH):0] trail_count;
    logic             overflow;

    always #5 clk = ~clk;

    mini_backtrack_unit #(.DEPTH(DEPTH), .VAR_W(VAR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .clear            (clear),
        .push_valid       (push_valid),
        .push_var         (push_var),
        .push_val         (push_val),
        .push_is_decision (push_is_decision),
        .push_flipped     (push_flipped),
        .bt_req           (bt_req),
        .bt_busy          (bt_busy),
        .unassign_valid   (unassign_valid),
        .unassign_var     (unassign_var),
        .unassign_ready   (unassign_ready),
        .flip_valid       (flip_valid),
        .flip_var         (flip_var),
        .flip_val         (flip_val),
        .unsat            (unsat),
        .level            (level),
        .trail_count      (trail_count),
        .overflow         (overflow)
    );

    typedef struct { int unsigned v; bit dec; } m_trail_t;
    typedef struct { int unsigned v; bit pos; bit neg; } m_dec_t;

    m_trail_t    m_trail[$];
    m_dec_t      m_dec[$];
    bit          m_ovf;
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned got_vars[$];
    int          n_flips, n_unsat, unsat_cyc, flip_cyc;
    logic [31:0] got_fvar;
    assign_val_t got_fval;
    bit          last_flip;
    int unsigned last_fvar;
    assign_val_t last_fval;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_trail.delete();
        m_dec.delete();
        m_ovf = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
    endtask

    task automatic do_push(input int unsigned v, input assign_val_t val, input bit dec, input bit flipped);
        push_valid       = 1'b1;
        push_var         = v;
        push_val         = val;
        push_is_decision = dec;
        push_flipped     = flipped;
        @(negedge clk);
        push_valid = 1'b0;
        if (m_trail.size() < DEPTH) begin
            m_trail.push_back('{v, dec});
            if (dec) m_dec.push_back('{v, flipped || (val == VAL_TRUE), flipped || (val == VAL_FALSE)});
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // mode 0: ready always high, 1: ready toggles, 2: ready random
    task automatic run_bt(input int mode, input string tag);
        int unsigned exp_vars[$];
        m_trail_t    e;
        m_dec_t      d;
        int          cyc;
        bit          r;
        bit          prev_stall;
        logic [31:0] prev_var;
        last_flip = 1'b0;
        last_fvar = 0;
        last_fval = VAL_UNDEF;
        while (m_dec.size() != 0) begin
            e = m_trail.pop_back();
            exp_vars.push_back(e.v);
            if (e.dec) begin
                d = m_dec.pop_back();
                if (!(d.pos && d.neg)) begin
                    last_flip = 1'b1;
                    last_fvar = d.v;
                    last_fval = d.pos ? VAL_FALSE : VAL_TRUE;
                    break;
                end
            end
        end
        got_vars.delete();
        n_flips = 0; n_unsat = 0; unsat_cyc = -1; flip_cyc = -1;
        prev_stall = 1'b0; prev_var = '0;
        bt_req = 1'b1;
        @(negedge clk);
        bt_req = 1'b0;
        check({tag, ":busy_n1"}, bt_busy, 1);
        cyc = 1;
        while (bt_busy && cyc < 2 * DEPTH + 50) begin
            if (prev_stall) begin
                check({tag, ":stall_valid"}, unassign_valid, 1);
                check({tag, ":stall_var"}, unassign_var, prev_var);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = cyc[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            unassign_ready = r;
            if (unassign_valid && r) got_vars.push_back(unassign_var);
            prev_stall = unassign_valid && !r;
            prev_var   = unassign_var;
            if (flip_valid) begin n_flips++; got_fvar = flip_var; got_fval = flip_val; flip_cyc = cyc; end
            if (unsat) begin n_unsat++; unsat_cyc = cyc; end
            @(negedge clk);
            cyc++;
        end
        unassign_ready = 1'b0;
        check({tag, ":done"}, bt_busy, 0);
        check({tag, ":n_unassign"}, got_vars.size(), exp_vars.size());
        for (int i = 0; i < exp_vars.size() && i < got_vars.size(); i++)
            check($sformatf("%s:unassign%0d", tag, i), got_vars[i], exp_vars[i]);
        check({tag, ":n_flip"}, n_flips, last_flip ? 1 : 0);
        check({tag, ":n_unsat"}, n_unsat, last_flip ? 0 : 1);
        if (last_flip) begin
            check({tag, ":flip_var"}, got_fvar, last_fvar);
            check({tag, ":flip_val"}, got_fval, last_fval);
        end
        check({tag, ":level"}, level, m_dec.size());
        check({tag, ":trail_count"}, trail_count, m_trail.size());
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1; clear = 1'b0; push_valid = 1'b0; push_var = '0; push_val = VAL_UNDEF;
        push_is_decision = 1'b0; push_flipped = 1'b0; bt_req = 1'b0; unassign_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst:bt_busy", bt_busy, 0);
        check("rst:unassign_valid", unassign_valid, 0);
        check("rst:unassign_var", unassign_var, 0);
        check("rst:flip_valid", flip_valid, 0);
        check("rst:flip_var", flip_var, 0);
        check("rst:flip_val", flip_val, VAL_UNDEF);
        check("rst:unsat", unsat, 0);
        check("rst:overflow", overflow, 0);
        check("rst:level", level, 0);
        check("rst:trail_count", trail_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // decision v1=TRUE, implied v2, v3; full-speed unwind then flip
        do_push(1, VAL_TRUE, 1, 0);
        do_push(2, VAL_TRUE, 0, 0);
        do_push(3, VAL_FALSE, 0, 0);
        check("s036:level_pre", level, 1);
        run_bt(0, "s036");
        check("s036:flip_cycle", flip_cyc, 4);

        // re-push flipped v1 and implied v4: exhausted -> UNSAT
        do_push(1, VAL_FALSE, 1, 1);
        do_push(4, VAL_TRUE, 0, 0);
        run_bt(0, "s037");

        // only a level-0 implication: no unassign, UNSAT two cycles after the request
        do_clear();
        do_push(7, VAL_TRUE, 0, 0);
        run_bt(0, "s038");
        check("s038:unsat_cycle", unsat_cyc, 2);

        // two levels with stalling consumer
        do_clear();
        do_push(1, VAL_FALSE, 1, 1);
        do_push(2, VAL_TRUE, 1, 0);
        do_push(5, VAL_TRUE, 0, 0);
        run_bt(1, "s039");

        // push while busy is dropped and flagged
        do_clear();
        do_push(9, VAL_TRUE, 1, 0);
        unassign_ready = 1'b0;
        bt_req = 1'b1;
        @(negedge clk);
        bt_req = 1'b0;
        push_valid = 1'b1; push_var = 10; push_val = VAL_TRUE; push_is_decision = 1'b0; push_flipped = 1'b0;
        @(negedge clk);
        push_valid = 1'b0;
        check("busy_push:overflow", overflow, 1);
        check("busy_push:trail_count", trail_count, 1);
        unassign_ready = 1'b1;
        cyc = 0;
        while (bt_busy && cyc < 20) begin @(negedge clk); cyc++; end
        unassign_ready = 1'b0;
        check("busy_push:done", bt_busy, 0);
        check("busy_push:flip_var", flip_var, 9);
        check("busy_push:flip_val", flip_val, VAL_FALSE);
        check("busy_push:trail_empty", trail_count, 0);

        // fill to capacity, then one more
        do_clear();
        for (int i = 0; i < DEPTH; i++) do_push(100 + i, VAL_TRUE, 0, 0);
        check("full:trail_count", trail_count, m_trail.size());
        check("full:overflow_low", overflow, m_ovf);
        do_push(999, VAL_TRUE, 0, 0);
        check("full:trail_count_held", trail_count, DEPTH);
        check("full:overflow_set", overflow, 1);
        do_clear();
        check("full:clear_overflow", overflow, 0);
        check("full:clear_trail", trail_count, 0);

        // reset in the middle of an unwind
        do_push(1, VAL_TRUE, 1, 0);
        do_push(2, VAL_FALSE, 1, 0);
        do_push(3, VAL_TRUE, 0, 0);
        unassign_ready = 1'b1;
        bt_req = 1'b1;
        @(negedge clk);
        bt_req = 1'b0;
        check("rst_mid:valid_before", unassign_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check("rst_mid:bt_busy", bt_busy, 0);
        check("rst_mid:unassign_valid", unassign_valid, 0);
        check("rst_mid:level", level, 0);
        check("rst_mid:trail_count", trail_count, 0);
        n_flips = 0; n_unsat = 0;
        for (int i = 0; i < 5; i++) begin
            if (flip_valid) n_flips++;
            if (unsat) n_unsat++;
            @(negedge clk);
        end
        unassign_ready = 1'b0;
        check("rst_mid:no_flip", n_flips, 0);
        check("rst_mid:no_unsat", n_unsat, 0);

        // random solver-like sequences
        for (int r = 0; r < 10; r++) begin
            int n;
            do_clear();
            n = $urandom_range(1, 24);
            for (int k = 0; k < n; k++) begin
                bit dec;
                dec = ($urandom_range(0, 2) == 0);
                do_push($urandom, $urandom_range(0, 1) ? VAL_TRUE : VAL_FALSE, dec,
                        dec && ($urandom_range(0, 3) == 0));
            end
            for (int b = 0; b < 3; b++) begin
                run_bt(2, $sformatf("rnd%0d_%0d", r, b));
                if (last_flip) do_push(last_fvar, last_fval, 1, 1);
                n = $urandom_range(0, 6);
                for (int k = 0; k < n; k++) begin
                    bit dec;
                    dec = ($urandom_range(0, 1) == 0);
                    do_push($urandom, $urandom_range(0, 1) ? VAL_TRUE : VAL_FALSE, dec, 1'b0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
